// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit (8 ops) with result/negative/zero/parity flags; latency STAGES cycles.
// Valid/ready on both sides: a stalled output fills the stages in turn, then in_ready drops; flush squashes in-flight work.
module logic_unit_pipe #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             parity
);

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             neg;
      logic             zro;
      logic             par;
   } pay_t;

   pay_t              stg [STAGES];
   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] adv;
   pay_t              nxt;
   logic              acc;

   always_comb begin
      nxt = '0;
      unique case (op)
         3'b000: nxt.res = a & b;
         3'b001: nxt.res = a | b;
         3'b010: nxt.res = a ^ b;
         3'b011: nxt.res = ~(a | b);
         3'b100: nxt.res = ~(a ^ b);
         3'b101: nxt.res = a & ~b;
         3'b110: nxt.res = ~a;
         3'b111: nxt.res = b;
      endcase
      // flags are derived from the result so they always agree with what is presented
      nxt.neg = nxt.res[WIDTH-1];
      nxt.zro = (nxt.res == '0);
      nxt.par = ^nxt.res;
   end

   // advance chain runs from the output back towards the input, so a free slot
   // anywhere downstream lets the whole chain move in the same cycle
   always_comb begin
      adv = '0;
      adv[STAGES-1] = vld[STAGES-1] & out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         adv[k] = vld[k] & (~vld[k+1] | adv[k+1]);
      end
   end

   assign in_ready = ~vld[0] | adv[0];
   assign acc      = in_valid & in_ready & ~flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld <= '0;
         for (int k = 0; k < STAGES; k++) begin
            stg[k] <= '0;
         end
      end else begin
         // payloads only move on real transfers; a flush leaves them untouched
         if (acc) begin
            stg[0] <= nxt;
         end
         vld[0] <= ~flush & (acc | (vld[0] & ~adv[0]));
         for (int k = 1; k < STAGES; k++) begin
            if (adv[k-1] && !flush) begin
               stg[k] <= stg[k-1];
            end
            vld[k] <= ~flush & (adv[k-1] | (vld[k] & ~adv[k]));
         end
      end
   end

   assign out_valid = vld[STAGES-1];
   assign result    = stg[STAGES-1].res;
   assign negative  = stg[STAGES-1].neg;
   assign zero      = stg[STAGES-1].zro;
   assign parity    = stg[STAGES-1].par;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed cases on a 64-bit/2-stage unit plus random traffic
// shared with 8-bit/1-stage and 128-bit/4-stage units, all checked against a queue model.
module tb_logic_unit_pipe;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic [2:0]   op = 3'b000;
   logic [127:0] a_in = '0;
   logic [127:0] b_in = '0;
   logic         out_ready = 1'b1;

   logic         in_ready8, out_valid8, negative8, zero8, parity8;
   logic [7:0]   result8;
   logic         in_ready64, out_valid64, negative64, zero64, parity64;
   logic [63:0]  result64;
   logic         in_ready128, out_valid128, negative128, zero128, parity128;
   logic [127:0] result128;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   logic_unit_pipe #(.WIDTH(8), .STAGES(1)) u8 (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready8), .op(op), .a(a_in[7:0]), .b(b_in[7:0]),
      .out_valid(out_valid8), .out_ready(out_ready), .result(result8),
      .negative(negative8), .zero(zero8), .parity(parity8));

   logic_unit_pipe #(.WIDTH(64), .STAGES(2)) u64 (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64), .op(op), .a(a_in[63:0]), .b(b_in[63:0]),
      .out_valid(out_valid64), .out_ready(out_ready), .result(result64),
      .negative(negative64), .zero(zero64), .parity(parity64));

   logic_unit_pipe #(.WIDTH(128), .STAGES(4)) u128 (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready128), .op(op), .a(a_in), .b(b_in),
      .out_valid(out_valid128), .out_ready(out_ready), .result(result128),
      .negative(negative128), .zero(zero128), .parity(parity128));

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] lop(input logic [2:0] o, input logic [127:0] x,
                                        input logic [127:0] y, input logic [127:0] msk);
      logic [127:0] r;
      case (o)
         3'd0:    r = x & y;
         3'd1:    r = x | y;
         3'd2:    r = x ^ y;
         3'd3:    r = ~(x | y);
         3'd4:    r = ~(x ^ y);
         3'd5:    r = x & ~y;
         3'd6:    r = ~x;
         default: r = y;
      endcase
      return r & msk;
   endfunction

   // reference model: one FIFO of expected results per unit, tagged with the acceptance edge
   logic [127:0] res_q [3][16];
   int           acc_q [3][16];
   int           hd [3];
   int           cnt [3];
   logic [127:0] last_res [3];
   logic [2:0]   last_flg [3];
   logic [127:0] log_res [64];
   logic [2:0]   log_flg [64];
   int           log_n = 0;

   task automatic sb_step(input int id, input int w, input int s, input logic rdy,
                          input logic ov, input logic [127:0] res,
                          input logic ng, input logic zr, input logic pr);
      logic [127:0] msk, e;
      logic [2:0]   ef;
      logic         ev, mrdy;
      msk  = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
      ev   = (cnt[id] > 0) && (cyc - acc_q[id][hd[id]] >= s - 1);
      mrdy = (cnt[id] < s) || out_ready;
      e    = ev ? res_q[id][hd[id]] : last_res[id];
      ef   = ev ? {e[w-1], (e == '0), ^e} : last_flg[id];
      chk($sformatf("out_valid_w%0d", w), ov, ev);
      chk($sformatf("result_w%0d", w), res, e);
      chk($sformatf("flags_w%0d", w), {ng, zr, pr}, ef);
      chk($sformatf("in_ready_w%0d", w), rdy, mrdy);
      if (ev) begin
         last_res[id] = e;
         last_flg[id] = ef;
      end
      if (id == 1 && ov && out_ready && log_n < 64) begin
         log_res[log_n] = res;
         log_flg[log_n] = {ng, zr, pr};
         log_n++;
      end
      if (ev && out_ready) begin
         hd[id] = (hd[id] + 1) % 16;
         cnt[id]--;
      end
      if (flush) begin
         cnt[id] = 0;
      end else if (in_valid && mrdy) begin
         res_q[id][(hd[id] + cnt[id]) % 16] = lop(op, a_in & msk, b_in & msk, msk);
         acc_q[id][(hd[id] + cnt[id]) % 16] = cyc + 1;
         cnt[id]++;
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) begin
            hd[i] = 0;
            cnt[i] = 0;
            last_res[i] = '0;
            last_flg[i] = '0;
         end
      end else begin
         sb_step(0, 8, 1, in_ready8, out_valid8, result8, negative8, zero8, parity8);
         sb_step(1, 64, 2, in_ready64, out_valid64, result64, negative64, zero64, parity64);
         sb_step(2, 128, 4, in_ready128, out_valid128, result128, negative128, zero128, parity128);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // present one bundle and hold it until the 64-bit unit takes it
   task automatic send(input logic [2:0] o, input logic [127:0] va, input logic [127:0] vb);
      int   n;
      logic got;
      in_valid = 1'b1;
      op = o;
      a_in = va;
      b_in = vb;
      n = 0;
      got = 1'b0;
      while (!got && n < 100) begin
         @(negedge clk);
         got = in_ready64 && !flush;
         @(posedge clk);
         #1;
         n++;
      end
      if (!got) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   logic [127:0] held;

   initial begin
      #2 reset_n = 1'b0;
      #1;
      chk("rst_out_valid64", out_valid64, 0);
      chk("rst_result64", result64, 0);
      chk("rst_flags64", {negative64, zero64, parity64}, 0);
      chk("rst_out_valid8", out_valid8, 0);
      chk("rst_out_valid128", out_valid128, 0);
      @(posedge clk);
      @(posedge clk);
      #2 reset_n = 1'b1;
      tick(1);

      // all eight ops back to back
      log_n = 0;
      for (int k = 0; k < 8; k++) begin
         send(3'(k), 128'hF0F0_0000_FFFF_1234, 128'h0FF0_0000_FF00_1234);
      end
      tick(4);
      chk("sweep_count", log_n, 8);
      chk("sweep_and", log_res[0], 128'h00F0_0000_FF00_1234);
      chk("sweep_or", log_res[1], 128'hFFF0_0000_FFFF_1234);
      chk("sweep_xor", log_res[2], 128'hFF00_0000_00FF_0000);
      chk("sweep_xor_flags", log_flg[2], 3'b100);
      chk("sweep_andn", log_res[5], 128'hF000_0000_00FF_0000);
      chk("sweep_not", log_res[6], 128'h0F0F_FFFF_0000_EDCB);
      chk("sweep_not_flags", log_flg[6], 3'b001);

      // flag corners
      log_n = 0;
      send(3'd2, 128'h1234, 128'h1234);
      send(3'd4, 128'h0, 128'h0);
      send(3'd7, 128'hDEAD, 128'h1);
      tick(4);
      chk("xor_zero_res", log_res[0], 0);
      chk("xor_zero_flags", log_flg[0], 3'b010);
      chk("xnor_ones_res", log_res[1], 128'hFFFF_FFFF_FFFF_FFFF);
      chk("xnor_ones_flags", log_flg[1], 3'b100);
      chk("passb_flags", log_flg[2], 3'b001);

      // backpressure: 6 bundles while the consumer stalls
      log_n = 0;
      fork
         begin
            for (int k = 1; k <= 6; k++) begin
               send(3'd7, 128'h0, 128'(k) * 128'h1111_1111_1111_1111);
            end
         end
         begin
            tick(3);
            out_ready = 1'b0;
            tick(4);
            @(negedge clk);
            chk("bp_in_ready", in_ready64, 0);
            chk("bp_out_valid", out_valid64, 1);
            held = result64;
            @(negedge clk);
            chk("bp_held_stable", result64, held);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      tick(5);
      chk("bp_count", log_n, 6);
      for (int k = 1; k <= 6; k++) begin
         chk($sformatf("bp_order%0d", k), log_res[k-1], 128'(k) * 128'h1111_1111_1111_1111);
      end

      // flush a full pipeline with a coincident input
      out_ready = 1'b0;
      send(3'd7, 128'h0, 128'hAAAA);
      send(3'd7, 128'h0, 128'hBBBB);
      in_valid = 1'b1;
      op = 3'd7;
      b_in = 128'hCCCC;
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", out_valid64, 0);
      chk("flush_in_ready", in_ready64, 1);
      log_n = 0;
      @(posedge clk);
      #1 out_ready = 1'b1;
      tick(5);
      chk("flush_nothing_out", log_n, 0);

      // asynchronous reset between clock edges
      for (int k = 0; k < 4; k++) begin
         send(3'd6, 128'(k), 128'h0);
      end
      #1;
      chk("pre_rst_out_valid", out_valid64, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_out_valid64", out_valid64, 0);
      chk("arst_result64", result64, 0);
      chk("arst_flags64", {negative64, zero64, parity64}, 0);
      chk("arst_result128", result128, 0);
      chk("arst_out_valid8", out_valid8, 0);
      @(posedge clk);
      #2 reset_n = 1'b1;
      tick(1);
      log_n = 0;
      send(3'd2, 128'hA5, 128'h5A);
      @(negedge clk);
      chk("lat_cycle1", out_valid64, 0);
      @(negedge clk);
      chk("lat_cycle2", out_valid64, 1);
      chk("lat_result", result64, 64'hFF);
      tick(3);
      chk("post_rst_count", log_n, 1);

      // random traffic: full-rate consumer first, then random backpressure and flushes
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(3) != 0);
         op        = 3'($urandom);
         a_in      = {$urandom, $urandom, $urandom, $urandom};
         b_in      = {$urandom, $urandom, $urandom, $urandom};
         out_ready = (c < 1000) ? 1'b1 : ($urandom_range(2) != 0);
         flush     = (c >= 1000) && ($urandom_range(31) == 0);
         tick(1);
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      tick(10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
